axi4_lite_mem_slave: RTL
========================

AXI4_LITE_MEM_SLAVE -- requirements
Module: axi4_lite_mem_slave

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, meaning byte-address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning data width in bits; only 32 or 64 are legal.
REQ-003 The block SHALL have parameter MEM_DEPTH, default 1024, meaning number of DATA_WIDTH words.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows.
- ACLK  in  1  clock, all logic on rising edge.
- ARESETN  in  1  asynchronous active-low reset.
- AWADDR/AWVALID/AWREADY  in/in/out  ADDR_WIDTH/1/1  write address channel.
- WDATA/WSTRB/WVALID/WREADY  in/in/in/out  DATA_WIDTH/DATA_WIDTH/8/1/1  write data channel.
- BRESP/BVALID/BREADY  out/out/in  2/1/1  write response channel.
- ARADDR/ARVALID/ARREADY  in/in/out  ADDR_WIDTH/1/1  read address channel.
- RDATA/RRESP/RVALID/RREADY  out/out/out/in  DATA_WIDTH/2/1/1  read data channel.

Function
REQ-005 Word index SHALL be ADDR >> log2(DATA_WIDTH/8); low address bits SHALL be ignored.
REQ-006 Index < MEM_DEPTH SHALL be in range (resp OKAY = 2'b00); otherwise SLVERR = 2'b10 with no memory update.
REQ-007 The write FSM SHALL have states W_IDLE, W_ADDR_HELD, W_DATA_HELD, W_RESP.
REQ-008 In W_IDLE, AWREADY=1 and WREADY=1; AW and W SHALL be accepted independently, in either order or in the same cycle.
REQ-009 W_IDLE SHALL go to W_ADDR_HELD on AW-only handshake (AWREADY=0, WREADY=1), to W_DATA_HELD on W-only handshake (WREADY=0, AWREADY=1), and to W_RESP on both.
REQ-010 W_ADDR_HELD and W_DATA_HELD SHALL go to W_RESP on the missing handshake.
REQ-011 On the edge entering W_RESP, the memory write SHALL commit, updating only byte lanes with WSTRB[i]=1; WSTRB=0 SHALL leave memory unchanged and respond OKAY.
REQ-012 W_RESP SHALL drive BVALID=1, AWREADY=0, WREADY=0, and a stable BRESP until BREADY=1; then it SHALL return to W_IDLE with AWREADY=WREADY=1 on the next cycle.
REQ-013 Write latency SHALL be BVALID high in the cycle after the completing AW/W handshake.
REQ-014 The read FSM SHALL have states R_IDLE (ARREADY=1, RVALID=0) and R_DATA (ARREADY=0, RVALID=1).
REQ-015 On an AR handshake, RDATA/RRESP SHALL be registered and R_DATA entered, so RVALID is high the next cycle; out-of-range reads SHALL return RDATA=0 and RRESP=SLVERR.
REQ-016 RDATA/RRESP SHALL stay stable while RVALID=1 and RREADY=0; on RREADY=1 the FSM SHALL return to R_IDLE, with no back-to-back accept in the same cycle.
REQ-017 The read and write FSMs SHALL be independent; when an AR handshake and a write commit hit the same word on the same edge, RDATA SHALL return pre-write data.
REQ-018 Outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-019 While ARESETN=0, all outputs SHALL be 0 (READYs, VALIDs, BRESP, RRESP, RDATA), and both FSMs SHALL be idle.
REQ-020 On the first edge after ARESETN rises, AWREADY, WREADY and ARREADY SHALL assert.
REQ-021 Reset asserted mid-transaction SHALL abandon it: no pending write commits, no response is issued, and memory contents are retained, not cleared.

Structure
REQ-022 The shared package axi4_lite_Defs SHALL hold the resp_t enum (OKAY, SLVERR), the wstate_t and rstate_t enums, and the RESP_OKAY/RESP_SLVERR constants.
REQ-023 Storage SHALL be the sub-module axi4_lite_mem: parametrised depth and width, one byte-strobed synchronous write port, one synchronous read port.
REQ-024 Both FSMs and the address decode SHALL reside in axi4_lite_mem_slave.

Verification
REQ-025 Write AW=0x10 and W=0xDEADBEEF with WSTRB=0xF in the same cycle -> BVALID next cycle, BRESP=OKAY; then read 0x10 -> RDATA=0xDEADBEEF, RRESP=OKAY.
REQ-026 W before AW by 3 cycles (AW=0x20, WSTRB=0x3, W=0x1234_5678, word previously 0xAAAA_AAAA) -> read 0x20 returns 0xAAAA_5678.
REQ-027 Write and read to 0x1000 with MEM_DEPTH=1024 and DATA_WIDTH=32 -> BRESP=SLVERR, RRESP=SLVERR, RDATA=0, and word 0 unchanged.
REQ-028 Hold BREADY=0 and RREADY=0 for 5 cycles -> BVALID/RVALID, BRESP/RDATA stable, AWREADY=WREADY=ARREADY=0 throughout.
REQ-029 Same-edge write 0x5555_5555 and read of 0x40 (old 0x0) -> RDATA=0x0, and a subsequent read returns 0x5555_5555.
REQ-030 Pulse ARESETN low while in W_ADDR_HELD -> all outputs 0, BVALID never asserts, and previously written words are intact.

Source files
------------

// File: rtl/axi4_lite_Defs.sv
// Shared definitions for the AXI4-Lite memory slave: response codes and
// the state encodings of the independent write and read FSMs.
package axi4_lite_Defs;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    OKAY   = RESP_OKAY,
    SLVERR = RESP_SLVERR
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_ADDR_HELD,
    W_DATA_HELD,
    W_RESP
  } wstate_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rstate_t;

  // In-range accesses answer OKAY, anything past the last word answers SLVERR.
  function automatic resp_t range_resp(input logic in_range);
    return in_range ? OKAY : SLVERR;
  endfunction

endpackage

// File: rtl/axi4_lite_mem.sv
// Word-organised storage with one byte-strobed synchronous write port and
// one synchronous read port. Contents are never reset, so they survive a
// bus reset. A read and a write to the same word on one edge return the
// old contents.
module axi4_lite_mem #(
  parameter  int DATA_WIDTH = 32,
  parameter  int MEM_DEPTH  = 1024,
  localparam int IDX_W      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1,
  localparam int LANES      = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [LANES-1:0]      wr_strb,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [LANES-1:0]      lane_we;

  // Per-lane write enables: the commit qualified by its byte strobe.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane_we
      assign lane_we[gi] = wr_en & wr_strb[gi];
    end
  endgenerate

  // Byte-lane writes and the registered read share one clocked process.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (lane_we[i]) begin
        mem[wr_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
      end
    end
    if (rd_en) begin
      rd_data <= mem[rd_idx];
    end
  end

endmodule

// File: rtl/axi4_lite_mem_slave.sv
// AXI4-Lite slave in front of a word memory. Independent write and read
// FSMs; every handshake/valid output comes from a flop, so no input reaches
// an output combinationally. Out-of-range words answer SLVERR and are never
// written; out-of-range reads return zero data. DATA_WIDTH is 32 or 64.
module axi4_lite_mem_slave
  import axi4_lite_Defs::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RVALID,
  input  logic                    RREADY
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int OFFS  = $clog2(LANES);
  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  wstate_t wstate_reg, wstate_next;
  rstate_t rstate_reg, rstate_next;

  logic awready_reg, wready_reg, bvalid_reg;
  logic arready_reg, rvalid_reg;
  resp_t bresp_reg, rresp_reg;

  logic [ADDR_WIDTH-1:0] awaddr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [LANES-1:0]      wstrb_reg;

  logic aw_hs, w_hs, ar_hs, wr_commit;
  logic [ADDR_WIDTH-1:0] wr_addr, wr_word, rd_word;
  logic [DATA_WIDTH-1:0] wr_data, mem_rdata;
  logic [LANES-1:0]      wr_strb;
  logic wr_in_range, rd_in_range;

  assign aw_hs = AWVALID & awready_reg;
  assign w_hs  = WVALID  & wready_reg;
  assign ar_hs = ARVALID & arready_reg;

  // The commit takes whichever half was captured earlier from its holding
  // register and the half completing now straight from the bus.
  assign wr_addr = (wstate_reg == W_ADDR_HELD) ? awaddr_reg : AWADDR;
  assign wr_data = (wstate_reg == W_DATA_HELD) ? wdata_reg  : WDATA;
  assign wr_strb = (wstate_reg == W_DATA_HELD) ? wstrb_reg  : WSTRB;

  // Byte address to word index; sub-word address bits are dropped.
  assign wr_word     = wr_addr >> OFFS;
  assign rd_word     = ARADDR  >> OFFS;
  assign wr_in_range = (wr_word < ADDR_WIDTH'(MEM_DEPTH));
  assign rd_in_range = (rd_word < ADDR_WIDTH'(MEM_DEPTH));

  // Write FSM next state; the commit fires on the edge that enters W_RESP.
  always_comb begin
    wstate_next = wstate_reg;
    wr_commit   = 1'b0;
    case (wstate_reg)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          wstate_next = W_RESP;
          wr_commit   = 1'b1;
        end else if (aw_hs) begin
          wstate_next = W_ADDR_HELD;
        end else if (w_hs) begin
          wstate_next = W_DATA_HELD;
        end
      end
      W_ADDR_HELD: begin
        if (w_hs) begin
          wstate_next = W_RESP;
          wr_commit   = 1'b1;
        end
      end
      W_DATA_HELD: begin
        if (aw_hs) begin
          wstate_next = W_RESP;
          wr_commit   = 1'b1;
        end
      end
      W_RESP: begin
        if (BREADY) begin
          wstate_next = W_IDLE;
        end
      end
      default: wstate_next = W_IDLE;
    endcase
  end

  // Write state, registered channel flags, held halves and the response.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wstate_reg  <= W_IDLE;
      awready_reg <= 1'b0;
      wready_reg  <= 1'b0;
      bvalid_reg  <= 1'b0;
      bresp_reg   <= OKAY;
      awaddr_reg  <= '0;
      wdata_reg   <= '0;
      wstrb_reg   <= '0;
    end else begin
      wstate_reg  <= wstate_next;
      awready_reg <= (wstate_next == W_IDLE) || (wstate_next == W_DATA_HELD);
      wready_reg  <= (wstate_next == W_IDLE) || (wstate_next == W_ADDR_HELD);
      bvalid_reg  <= (wstate_next == W_RESP);
      if (aw_hs) begin
        awaddr_reg <= AWADDR;
      end
      if (w_hs) begin
        wdata_reg <= WDATA;
        wstrb_reg <= WSTRB;
      end
      if (wr_commit) begin
        bresp_reg <= range_resp(wr_in_range);
      end
    end
  end

  // Read FSM next state: one accepted address, then hold data until taken.
  always_comb begin
    rstate_next = rstate_reg;
    case (rstate_reg)
      R_IDLE:  if (ar_hs)  rstate_next = R_DATA;
      R_DATA:  if (RREADY) rstate_next = R_IDLE;
      default: rstate_next = R_IDLE;
    endcase
  end

  // Read state, registered channel flags and the read response code.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rstate_reg  <= R_IDLE;
      arready_reg <= 1'b0;
      rvalid_reg  <= 1'b0;
      rresp_reg   <= OKAY;
    end else begin
      rstate_reg  <= rstate_next;
      arready_reg <= (rstate_next == R_IDLE);
      rvalid_reg  <= (rstate_next == R_DATA);
      if (ar_hs) begin
        rresp_reg <= range_resp(rd_in_range);
      end
    end
  end

  axi4_lite_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_mem (
    .clk     (ACLK),
    .wr_en   (wr_commit & wr_in_range),
    .wr_idx  (wr_word[IDX_W-1:0]),
    .wr_strb (wr_strb),
    .wr_data (wr_data),
    .rd_en   (ar_hs & rd_in_range),
    .rd_idx  (rd_word[IDX_W-1:0]),
    .rd_data (mem_rdata)
  );

  assign AWREADY = awready_reg;
  assign WREADY  = wready_reg;
  assign BVALID  = bvalid_reg;
  assign BRESP   = bresp_reg;
  assign ARREADY = arready_reg;
  assign RVALID  = rvalid_reg;
  assign RRESP   = rresp_reg;
  // The memory output register is not reset; it only reaches RDATA while a
  // valid in-range response is being presented.
  assign RDATA   = (rvalid_reg && (rresp_reg == RESP_OKAY)) ? mem_rdata : '0;

endmodule
